out_port_fifo: RTL and testbench

- Output-side buffer between the processor core's output strobe (out_en / addr_out / data_out) and the peripherals.
- The core cannot stall, so this block absorbs bursts of OUT instructions in a circular buffer plus a registered output stage.
- It drains them over a valid/ready interface with a one-hot port select.
- Writes arriving when the buffer is full are dropped and flagged with a sticky overflow bit.

---
 rtl/out_port_fifo.sv | 118 +++++++++++
 tb/tb_out_port_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/out_port_fifo.sv
// Output-port buffer between the core's OUT strobe and the peripherals.
// Words sit in a circular array and then in a registered output stage. They
// drain over valid/ready with a one-hot port select. A push that arrives while
// every slot is full is dropped, and the sticky ovf bit is raised.
module out_port_fifo #(
  parameter int NUBITS = 32,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 8,
  parameter int NBOADR = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  parameter int NBLVL  = $clog2(FDEPTH + 1) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [NBOADR-1:0] wr_addr,
  input  logic [NUBITS-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NBOADR-1:0] out_addr,
  output logic [NUBITS-1:0] out_data,
  output logic [NUIOOU-1:0] out_sel,
  output logic [NBLVL-1:0]  level,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int PW = $clog2(FDEPTH);
  localparam logic [NBLVL-1:0] CAP = NBLVL'(FDEPTH + 1);

  // Each array entry keeps the port address together with its data word
  logic [NBOADR+NUBITS-1:0] mem [FDEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [NBOADR-1:0]        addr_in;
  logic [NBLVL-1:0]         arr_level;
  logic                     pop;
  logic                     push_ok;
  logic                     load_out;
  logic                     arr_empty;
  logic                     push_to_arr;

  // Handshake decode. The array holds every stored word except the one in
  // the output register. A push goes straight to the output register only
  // when that register is free and nothing is queued ahead of the new word.
  always_comb begin
    addr_in     = (NUIOOU == 1) ? '0 : wr_addr;
    pop         = out_valid & out_ready;
    push_ok     = wr_en & ((level < CAP) | pop);
    load_out    = ~out_valid | pop;
    arr_level   = level - NBLVL'(out_valid);
    arr_empty   = (arr_level == '0);
    push_to_arr = push_ok & ~(load_out & arr_empty);
  end

  assign empty = (level == '0);
  assign full  = (level == CAP);

  // The array storage has no reset, because reset discards words through the
  // pointers and the level counter.
  always_ff @(posedge clk) begin
    if (push_to_arr) begin
      mem[wr_ptr] <= {addr_in, wr_data};
    end
  end

  // Load the output stage, advance the pointers, track the level and update the sticky overflow bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (load_out) begin
        if (!arr_empty) begin
          {out_addr, out_data} <= mem[rd_ptr];
          rd_ptr               <= rd_ptr + PW'(1);
          out_valid            <= 1'b1;
        end else if (push_ok) begin
          out_addr  <= addr_in;
          out_data  <= wr_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (push_to_arr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + NBLVL'(1);
        2'b01:   level <= level - NBLVL'(1);
        default: level <= level;
      endcase
      if (wr_en && !push_ok) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // One-hot port select. An address with no matching port leaves every bit at zero.
  always_comb begin
    out_sel = '0;
    for (int i = 0; i < NUIOOU; i++) begin
      if (out_valid && (out_addr == NBOADR'(i))) begin
        out_sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo. Accepted words go into a scoreboard queue.
// The head of that queue must match the output stage whenever words are held.
module tb_out_port_fifo;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_addr;
  logic [31:0] out_data;
  logic [7:0]  out_sel;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        clr_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  logic [34:0] sb_q[$];
  int          m_level = 0;
  logic        m_ovf   = 1'b0;

  out_port_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_sel(out_sel), .level(level), .empty(empty),
    .full(full), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    logic [34:0] head;
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'(m_level > 0));
    checkOutput({tag, ".level"}, 64'(level), 64'(m_level));
    checkOutput({tag, ".empty"}, 64'(empty), 64'(m_level == 0));
    checkOutput({tag, ".full"}, 64'(full), 64'(m_level == 9));
    checkOutput({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    if (m_level > 0 && sb_q.size() > 0) begin
      head = sb_q[0];
      checkOutput({tag, ".addr"}, 64'(out_addr), 64'(head[34:32]));
      checkOutput({tag, ".data"}, 64'(out_data), 64'(head[31:0]));
      checkOutput({tag, ".sel"}, 64'(out_sel), 64'(8'b1 << head[34:32]));
    end else begin
      checkOutput({tag, ".sel"}, 64'(out_sel), 64'd0);
    end
  endtask

  // Drive one cycle of inputs, check before the edge, then advance the model
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] a,
                               input logic [31:0] d, input logic rdy, input logic clr);
    logic m_pop;
    logic m_acc;
    wr_en     = we;
    wr_addr   = we ? a : 3'bxxx;
    wr_data   = we ? d : 32'hxxxx_xxxx;
    out_ready = rdy;
    clr_ovf   = clr;
    @(negedge clk);
    checkModel(tag);
    m_pop = (m_level > 0) && rdy;
    m_acc = we && ((m_level < 9) || m_pop);
    if (m_pop) void'(sb_q.pop_front());
    if (m_acc) sb_q.push_back({a, d});
    m_level = m_level + int'(m_acc) - int'(m_pop);
    if (we && !m_acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    checkModel("reset");
    checkOutput("reset.addr", 64'(out_addr), 64'd0);
    checkOutput("reset.data", 64'(out_data), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] single write");
    applyStimulus("single.wr", 1'b1, 3'd3, 32'h0000_00A5, 1'b1, 1'b0);
    applyStimulus("single.out", 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("single.idle", 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 9; i++)
      applyStimulus("fill", 1'b1, 3'(i % 8), 32'(i), 1'b0, 1'b0);
    applyStimulus("ovf.wr", 1'b1, 3'd2, 32'd10, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus("drain", 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("clr", 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);

    $display("[TB] push and pop while full");
    for (int i = 0; i < 9; i++)
      applyStimulus("refill", 1'b1, 3'(i), 32'h20 + 32'(i), 1'b0, 1'b0);
    applyStimulus("full.pushpop", 1'b1, 3'd5, 32'h30, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus("drain2", 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);

    $display("[TB] continuous writes, ready toggling");
    for (int i = 0; i < 24; i++)
      applyStimulus("stream", 1'b1, 3'(i * 3), 32'h40 + 32'(i), 1'(i % 2 == 0), 1'b0);

    $display("[TB] clear versus overflow");
    applyStimulus("clr.ovfwr", 1'b1, 3'd1, 32'h99, 1'b0, 1'b1);
    applyStimulus("clr.alone", 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus("clr.done", 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-drain");
    while (m_level > 5)
      applyStimulus("todrain", 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("prereset.level", 64'(level), 64'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst.valid", 64'(out_valid), 64'd0);
    checkOutput("arst.level", 64'(level), 64'd0);
    checkOutput("arst.sel", 64'(out_sel), 64'd0);
    sb_q.delete();
    m_level = 0;
    m_ovf   = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus("post.wr", 1'b1, 3'd0, 32'h1234, 1'b0, 1'b0);
    applyStimulus("post.out", 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("post.idle", 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
